sdram_rd_checker: RTL

SDRAM_RD_CHECKER -- requirements
Module: sdram_rd_checker

---
 rtl/sdram_rd_checker.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sdram_rd_checker.sv
// Checks the incrementing test pattern (1, 2, 3, ...) that an SDRAM test driver reads back.
// Optional idle watchdog enabled by defining CHK_TIMEOUT_EN.
module sdram_rd_checker #(
    parameter int DW        = 16,
    parameter int LW        = 10,
    parameter int TO_CYCLES = 4096
) (
    input  logic          clk,
    input  logic          res,
    input  logic          start,
    input  logic [LW-1:0] data_len,
    input  logic          rd_vld,
    input  logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [15:0]   err_cnt,
    output logic [LW-1:0] first_err_idx,
    output logic [DW-1:0] first_err_data,
    output logic          timeout
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    if (TO_CYCLES < 1) begin : g_bad_to_cycles
        $error("sdram_rd_checker: TO_CYCLES must be at least 1");
    end

    state_t        state_q;
    logic          start_q;
    logic          start_lo_seen_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] idx_q;
    logic [DW-1:0] expect_q;
    logic          busy_q;
    logic          done_q;
    logic          pass_q;
    logic [15:0]   err_cnt_q;
    logic [LW-1:0] first_err_idx_q;
    logic [DW-1:0] first_err_data_q;

    logic          start_edge_d;
    logic          mismatch_d;
    logic [15:0]   err_cnt_d;

    // start_q clears in reset, so a level already high at release would look like an
    // edge; start_lo_seen_q insists on seeing start low after reset before arming.
    assign start_edge_d = start & ~start_q & start_lo_seen_q;
    assign mismatch_d   = (rd_data != expect_q);
    assign err_cnt_d    = (mismatch_d && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;

`ifdef CHK_TIMEOUT_EN
    localparam int            TW      = $clog2(TO_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYCLES - 1);

    logic [TW-1:0] to_cnt_q;
    logic          timeout_q;

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q          <= S_IDLE;
            start_q          <= 1'b0;
            start_lo_seen_q  <= 1'b0;
            len_q            <= '0;
            idx_q            <= '0;
            expect_q         <= DW'(1);
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            err_cnt_q        <= '0;
            first_err_idx_q  <= '0;
            first_err_data_q <= '0;
`ifdef CHK_TIMEOUT_EN
            to_cnt_q         <= '0;
            timeout_q        <= 1'b0;
`endif
        end else begin
            start_q <= start;
            if (!start) begin
                start_lo_seen_q <= 1'b1;
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_edge_d) begin
                        state_q          <= S_RUN;
                        len_q            <= data_len;
                        idx_q            <= '0;
                        expect_q         <= DW'(1);
                        busy_q           <= 1'b1;
                        done_q           <= 1'b0;
                        pass_q           <= 1'b0;
                        err_cnt_q        <= '0;
                        first_err_idx_q  <= '0;
                        first_err_data_q <= '0;
`ifdef CHK_TIMEOUT_EN
                        to_cnt_q         <= '0;
                        timeout_q        <= 1'b0;
`endif
                    end
                end

                S_RUN: begin
                    if (rd_vld) begin
                        expect_q  <= expect_q + DW'(1);
                        idx_q     <= idx_q + LW'(1);
                        err_cnt_q <= err_cnt_d;
                        // Only the first mismatch of a run is recorded.
                        if (mismatch_d && (err_cnt_q == 16'd0)) begin
                            first_err_idx_q  <= idx_q;
                            first_err_data_q <= rd_data;
                        end
`ifdef CHK_TIMEOUT_EN
                        to_cnt_q <= '0;
`endif
                        if (idx_q == len_q) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_cnt_d == 16'd0);
                        end
                    end
`ifdef CHK_TIMEOUT_EN
                    else if (to_cnt_q == TO_LAST) begin
                        state_q   <= S_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        pass_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + TW'(1);
                    end
`endif
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_idx  = first_err_idx_q;
    assign first_err_data = first_err_data_q;

endmodule
